reg_ctrl_multi: RTL
===================

Name: reg_ctrl_multi

Overview:
- Parametrised successor to the team's single-bank register controller.
- Provides NUM_REGS software-accessible registers of DATA_W bits behind the sel/wr/addr/wdata/rdata/ready bus.
- Adds byte strobes, per-bit read-only masking, an out-of-range error flag, a configurable read wait, and a flat register image for hardware consumers.
- Sits between the testbench/CPU-side bus driver and datapath blocks that consume configuration.

Parameters:
- DATA_W, 16, register and bus data width; multiple of 8.
- NUM_REGS, 8, number of implemented registers; at least 1.
- ADDR_W, 8, address width; 2**ADDR_W >= NUM_REGS.
- READ_WAIT, 1, cycles ready is held low after an accepted read; at least 1.
- RST_VAL, all zeros, packed NUM_REGS*DATA_W reset image; register i occupies slice [i*DATA_W +: DATA_W].
- RO_MASK, all zeros, packed NUM_REGS*DATA_W; a 1 marks that bit read-only (software writes ignored).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  access request.
- wr  in  1  1 = write, 0 = read; sampled with sel.
- addr  in  ADDR_W  word index of the register.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte-lane write enables.
- rdata  out  DATA_W  read data, registered.
- ready  out  1  1 = controller accepts an access this cycle.
- err  out  1  status of the last accepted access; 1 = address out of range.
- regs_o  out  NUM_REGS*DATA_W  current contents of all registers.

Behaviour:
- Reset (async, rst=1):
  - Registers load RST_VAL.
  - rdata=0, err=0, ready=1, FSM=IDLE, wait counter=0.
  - Reset asserted mid-read aborts the wait immediately. ready is 1 in the first cycle after rst deasserts.
- Acceptance: an access is accepted on a rising edge where sel=1 and ready=1. sel while ready=0 is ignored; the bus master must hold or retry.
- In-range test: addr < NUM_REGS.
- Write, in range, at the accepting edge:
  - For each byte lane b with wstrb[b]=1, update each bit whose RO_MASK bit is 0 to the wdata bit.
  - All other bits are unchanged.
  - err<=0; ready stays 1, so back-to-back writes run every cycle.
- Write, out of range: no register changes; err<=1; ready stays 1.
- Read, in range, at the accepting edge:
  - rdata<=register[addr] with the full word; RO bits are readable.
  - err<=0; FSM moves to WAIT; ready<=0.
- Read, out of range: rdata<=0; err<=1; FSM moves to WAIT.
- WAIT state:
  - ready is low for exactly READ_WAIT cycles, then FSM returns to IDLE with ready=1.
  - The counter loads READ_WAIT-1 on entry and decrements; it exits when it reaches 0.
  - Read-to-read spacing is therefore READ_WAIT+1 cycles.
- Hold rules:
  - rdata holds until the next accepted read; writes never change rdata.
  - err holds until the next accepted access.
- regs_o reflects register state combinationally from the registers, so new values are visible the cycle after the write edge.
- wstrb=0 on a write: no change, err=0. This is legal and is not an error.
- FSM states: IDLE (ready=1) and WAIT (ready=0). There are no other states; an illegal encoding returns to IDLE.

Decomposition:
- reg_ctrl_pkg holds:
  - typedef enum logic {IDLE, WAIT} rc_state_e.
  - Default width constants.
  - A function merge_bytes(old, wdata, wstrb, romask) that returns the updated word.
- No sub-module is needed: registers, FSM and counter live in reg_ctrl_multi.

Test Plan (defaults unless stated):
- Reset with RST_VAL reg2=16'hA5A5 → ready=1, err=0, rdata=0; reading addr 2 gives rdata=16'hA5A5 one edge later and ready=0 for 1 cycle.
- Write addr 3 wdata=16'hBEEF wstrb=2'b01, then read addr 3 → rdata=16'h00EF, err=0.
- RO_MASK reg1=16'hFF00: write addr 1 with 16'h1234 and wstrb=2'b11 → rdata=16'h0034 and regs_o[31:16]=16'h0034.
- Write addr 8 then read addr 200 → err=1 on both; no regs_o change; rdata=0.
- READ_WAIT=3: read addr 0 with sel held high → ready low for exactly 3 cycles and the next read is accepted 4 cycles later; a sel pulse during the wait is ignored.
- Read accepted, then assert rst during the wait → ready=1 and rdata=0 immediately; registers return to RST_VAL.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared types, default widths and byte-merge helper for reg_ctrl_multi
package reg_ctrl_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} rc_state_e;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_REGS  = 8;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_READ_WAIT = 1;

  // Widest word the helper handles; callers zero-extend into it and keep the low DATA_W bits.
  localparam int MERGE_W = 256;

  function automatic logic [MERGE_W-1:0] merge_bytes(
    input logic [MERGE_W-1:0]   old_word,
    input logic [MERGE_W-1:0]   wdata,
    input logic [MERGE_W/8-1:0] wstrb,
    input logic [MERGE_W-1:0]   romask
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MERGE_W / 8; b++) begin
      if (wstrb[b]) begin
        for (int k = 0; k < 8; k++) begin
          if (!romask[b*8+k]) res[b*8+k] = wdata[b*8+k];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_ctrl_multi.sv
// rtl/reg_ctrl_multi.sv - NUM_REGS x DATA_W register bank with byte strobes, RO mask, range error and read wait
module reg_ctrl_multi
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int READ_WAIT = DEF_READ_WAIT,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RO_MASK = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sel,
  input  logic                         wr,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  output logic                         err,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_WAIT - 1);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  rc_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_err;

  logic                 w_in_range;
  logic [IDX_W-1:0]     w_idx;
  logic [DATA_W-1:0]    w_merged;
  logic [MERGE_W-1:0]   w_old_ext;
  logic [MERGE_W-1:0]   w_wdata_ext;
  logic [MERGE_W-1:0]   w_ro_ext;
  logic [MERGE_W/8-1:0] w_strb_ext;
  logic [MERGE_W-1:0]   w_merge_unused_hi;

  assign w_in_range = (32'(addr) < 32'(NUM_REGS));
  assign w_idx      = addr[IDX_W-1:0];

  always_comb begin
    w_old_ext   = '0;
    w_wdata_ext = '0;
    w_ro_ext    = '0;
    w_strb_ext  = '0;
    w_old_ext[DATA_W-1:0]     = r_regs[w_idx];
    w_wdata_ext[DATA_W-1:0]   = wdata;
    w_ro_ext[DATA_W-1:0]      = RO_MASK[w_idx*DATA_W +: DATA_W];
    w_strb_ext[DATA_W/8-1:0]  = wstrb;
    w_merge_unused_hi = merge_bytes(w_old_ext, w_wdata_ext, w_strb_ext, w_ro_ext);
    w_merged          = w_merge_unused_hi[DATA_W-1:0];
  end

  // IDLE always has ready=1, so sel in IDLE is an accepted access; sel in WAIT is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (sel) begin
            r_err <= !w_in_range;
            if (wr) begin
              if (w_in_range) r_regs[w_idx] <= w_merged;
            end else begin
              r_rdata <= w_in_range ? r_regs[w_idx] : '0;
              r_state <= WAIT;
              r_ready <= 1'b0;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_img
    assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;

endmodule
